// File: rtl/store_write_buffer.sv
// store_write_buffer: post-commit FIFO of committed stores that drains to the shared memory port
// when the load path is idle, with youngest-match store-to-load forwarding.
`default_nettype none

module store_write_buffer #(
    parameter int WB_DEPTH = 8,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sq_store_valid,
    input  logic [ADDR_W-1:0] sq_store_addr,
    input  logic [DATA_W-1:0] sq_store_value,
    output logic              wb_full,
    output logic              wb_empty,
    output logic              wb_overflow,
    input  logic              load_mem_req,
    input  logic [3:0]        mem2proc_response,
    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    input  logic              ld_lookup_valid,
    input  logic [ADDR_W-1:0] ld_lookup_addr,
    output logic              ld_fwd_hit,
    output logic [DATA_W-1:0] ld_fwd_data
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr [WB_DEPTH];
    logic [DATA_W-1:0]   r_data [WB_DEPTH];
    logic [WB_DEPTH-1:0] r_valid;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;

    logic                w_full;
    logic                w_push;
    logic                w_issue;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count_next;

    assign w_full  = (r_count == CNT_W'(WB_DEPTH));
    assign w_push  = sq_store_valid && !w_full;
    // ISSUE is only ever held with a nonzero count, so head is always a live entry here.
    assign w_issue = (r_state == S_ISSUE) && !load_mem_req;
    assign w_pop   = w_issue && (mem2proc_response != 4'd0);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (sq_store_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            // Head and tail only coincide when empty or full; a push at full is rejected,
            // so these two valid-bit writes never target the same entry in one cycle.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_state <= (w_count_next != '0) ? S_ISSUE : S_IDLE;
        end
    end

    // Payload storage needs no reset: entries are qualified by r_valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_tail] <= sq_store_addr;
            r_data[r_tail] <= sq_store_value;
        end
    end

    assign wb_full     = w_full;
    assign wb_empty    = (r_count == '0);
    assign wb_overflow = r_overflow;

    assign proc2mem_command = w_issue ? BUS_STORE : BUS_NONE;
    assign proc2mem_addr    = w_issue ? r_addr[r_head] : '0;
    assign proc2mem_data    = w_issue ? r_data[r_head] : '0;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        ld_fwd_hit  = 1'b0;
        ld_fwd_data = '0;
        w_idx       = '0;
        if (ld_lookup_valid) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                w_idx = r_head + PTR_W'(i);
                if (r_valid[w_idx] && (r_addr[w_idx] == ld_lookup_addr)) begin
                    ld_fwd_hit  = 1'b1;
                    ld_fwd_data = r_data[w_idx];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed stimulus with an expected-store queue checked by an
// independent monitor on every accepted memory store.
`default_nettype none

module tb_store_write_buffer;

    localparam int WB_DEPTH = 8;
    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } st_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              sq_store_valid = 1'b0;
    logic [ADDR_W-1:0] sq_store_addr = '0;
    logic [DATA_W-1:0] sq_store_value = '0;
    logic              wb_full, wb_empty, wb_overflow;
    logic              load_mem_req = 1'b0;
    logic [3:0]        mem2proc_response = 4'd0;
    logic [1:0]        proc2mem_command;
    logic [ADDR_W-1:0] proc2mem_addr;
    logic [DATA_W-1:0] proc2mem_data;
    logic              ld_lookup_valid = 1'b0;
    logic [ADDR_W-1:0] ld_lookup_addr = '0;
    logic              ld_fwd_hit;
    logic [DATA_W-1:0] ld_fwd_data;

    int  checks   = 0;
    int  failures = 0;
    st_t exp_q[$];

    store_write_buffer #(
        .WB_DEPTH(WB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clock(clock), .reset(reset),
        .sq_store_valid(sq_store_valid), .sq_store_addr(sq_store_addr),
        .sq_store_value(sq_store_value),
        .wb_full(wb_full), .wb_empty(wb_empty), .wb_overflow(wb_overflow),
        .load_mem_req(load_mem_req), .mem2proc_response(mem2proc_response),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .ld_lookup_valid(ld_lookup_valid), .ld_lookup_addr(ld_lookup_addr),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every store the memory accepts must be the oldest outstanding expected store.
    always @(negedge clock) begin
        if (reset && proc2mem_command == 2'd2 && mem2proc_response != 4'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_store: actual addr=0x%0h required none", proc2mem_addr);
            end else begin
                st_t e;
                e = exp_q.pop_front();
                check("drain_addr", proc2mem_addr, e.addr);
                check("drain_data", proc2mem_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit accept);
        sq_store_valid = 1'b1;
        sq_store_addr  = a;
        sq_store_value = d;
        if (accept) exp_q.push_back('{addr: a, data: d});
        tick();
        sq_store_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!wb_empty && n < 40) begin
            tick();
            n++;
        end
        check(name, {63'd0, wb_empty}, 64'd1);
    endtask

    initial begin
        // 1: reset values
        #12;
        check("rst_empty", {63'd0, wb_empty}, 64'd1);
        check("rst_full", {63'd0, wb_full}, 64'd0);
        check("rst_cmd", {62'd0, proc2mem_command}, 64'd0);
        check("rst_hit", {63'd0, ld_fwd_hit}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // 2: single store, memory accepts immediately
        mem2proc_response = 4'd1;
        push(64'hF1, 64'h000F, 1'b1);
        check("t2_cmd", {62'd0, proc2mem_command}, 64'd2);
        check("t2_addr", proc2mem_addr, 64'hF1);
        check("t2_data", proc2mem_data, 64'h000F);
        tick();
        check("t2_empty", {63'd0, wb_empty}, 64'd1);
        check("t2_cmd_idle", {62'd0, proc2mem_command}, 64'd0);

        // 3: load path owns the port for 3 cycles
        load_mem_req = 1'b1;
        push(64'hF1, 64'h000F, 1'b1);
        check("t3_cmd_blk0", {62'd0, proc2mem_command}, 64'd0);
        push(64'hF2, 64'h00F0, 1'b1);
        check("t3_cmd_blk1", {62'd0, proc2mem_command}, 64'd0);
        tick();
        check("t3_cmd_blk2", {62'd0, proc2mem_command}, 64'd0);
        check("t3_addr_blk", proc2mem_addr, 64'd0);
        load_mem_req = 1'b0;
        wait_empty("t3_drained");

        // 4: memory stalls; fill, overflow, then drain
        mem2proc_response = 4'd0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            push(64'h200 + 64'(i * 8), 64'hD0 + 64'(i), 1'b1);
        end
        check("t4_full", {63'd0, wb_full}, 64'd1);
        check("t4_no_ovf", {63'd0, wb_overflow}, 64'd0);
        check("t4_rejected_cmd", {62'd0, proc2mem_command}, 64'd2);
        check("t4_rejected_addr", proc2mem_addr, 64'h200);
        push(64'h999, 64'hDEAD, 1'b0);
        check("t4_ovf", {63'd0, wb_overflow}, 64'd1);
        check("t4_still_full", {63'd0, wb_full}, 64'd1);
        mem2proc_response = 4'd1;
        for (int i = 0; i < WB_DEPTH; i++) tick();
        check("t4_empty", {63'd0, wb_empty}, 64'd1);

        // 5: forwarding, youngest match wins; same-cycle store invisible
        mem2proc_response = 4'd0;
        push(64'h100, 64'hAA, 1'b1);
        push(64'h100, 64'hBB, 1'b1);
        ld_lookup_valid = 1'b1;
        ld_lookup_addr  = 64'h100;
        #1;
        check("t5_hit", {63'd0, ld_fwd_hit}, 64'd1);
        check("t5_data", ld_fwd_data, 64'hBB);
        ld_lookup_addr = 64'h108;
        #1;
        check("t5_miss_hit", {63'd0, ld_fwd_hit}, 64'd0);
        check("t5_miss_data", ld_fwd_data, 64'd0);
        sq_store_valid = 1'b1;
        sq_store_addr  = 64'h108;
        sq_store_value = 64'hCC;
        #1;
        check("t5_sameclk_hit", {63'd0, ld_fwd_hit}, 64'd0);
        sq_store_valid = 1'b0;
        ld_lookup_valid = 1'b0;
        #1;
        check("t5_novalid_hit", {63'd0, ld_fwd_hit}, 64'd0);
        mem2proc_response = 4'd1;
        wait_empty("t5_drained");

        // 6: async reset mid-drain with 3 entries
        mem2proc_response = 4'd0;
        push(64'h300, 64'h1, 1'b1);
        push(64'h308, 64'h2, 1'b1);
        push(64'h310, 64'h3, 1'b1);
        ld_lookup_valid = 1'b1;
        ld_lookup_addr  = 64'h308;
        #1;
        check("t6_pre_hit", {63'd0, ld_fwd_hit}, 64'd1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("t6_cmd", {62'd0, proc2mem_command}, 64'd0);
        check("t6_addr", proc2mem_addr, 64'd0);
        check("t6_empty", {63'd0, wb_empty}, 64'd1);
        check("t6_ovf", {63'd0, wb_overflow}, 64'd0);
        check("t6_hit", {63'd0, ld_fwd_hit}, 64'd0);
        ld_lookup_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        mem2proc_response = 4'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_post_cmd", {62'd0, proc2mem_command}, 64'd0);
        end

        check("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
